// File: rtl/int_alu_scheduler.sv
// int_alu_scheduler: issues tagged integer ops to ADD/SUB/MUL/DIV units and
// drains their held results onto the single CDB port in round-robin order.
package int_alu_pkg;
   localparam int INT_DATA_W = 32;
endpackage

module int_alu_unit #(
   parameter int DATA_W = 32,
   parameter int OP = 0,
   parameter int LAT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic [DATA_W-1:0] res
);
   logic [DATA_W-1:0] res_q, res_d;
   logic [3:0] cnt_q, cnt_d;
   always_comb begin
      res_d = res_q;
      cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
      if (start) begin
         res_d = (OP == 0) ? a + b : (OP == 1) ? a - b : (OP == 2) ? a * b : (b == '0) ? '0 : a / b;
         cnt_d = 4'(LAT);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         res_q <= '0;
         cnt_q <= '0;
      end else begin
         res_q <= res_d;
         cnt_q <= cnt_d;
      end
   end
   assign busy = cnt_q != 4'd0;
   assign res = res_q;
endmodule

module int_alu_scheduler
   import int_alu_pkg::*;
#(
   parameter int DATA_W = INT_DATA_W,
   parameter int TAG_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   input  logic [1:0]        issue_op,
   input  logic [DATA_W-1:0] issue_a,
   input  logic [DATA_W-1:0] issue_b,
   input  logic [TAG_W-1:0]  issue_tag,
   output logic              issue_ready,
   output logic [3:0]        unit_free,
   input  logic              flush,
   output logic              wb_valid,
   output logic [TAG_W-1:0]  wb_tag,
   output logic [DATA_W-1:0] wb_data,
   input  logic              wb_ready
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} st_t;
   st_t st_q [4], st_d [4];
   logic [TAG_W-1:0] tag_q [4], tag_d [4];
   logic [DATA_W-1:0] hold_q [4], hold_d [4], res [4];
   logic [3:0] sq_q, sq_d, bprev_q, bprev_d, busy, start, cmp, done;
   logic [1:0] ptr_q, ptr_d, gnt_q, gnt_d, rr, gnt;
   logic lock_q, lock_d, fire, hs;

   for (genvar g = 0; g < 4; g++) begin : g_unit
      int_alu_unit #(.DATA_W(DATA_W), .OP(g), .LAT(g == 2 ? 4 : g == 3 ? 8 : 0)) u_unit (
         .clk(clk), .rst(rst), .start(start[g]), .a(issue_a), .b(issue_b), .busy(busy[g]), .res(res[g]));
      assign done[g] = st_q[g] == DONE;
      assign unit_free[g] = st_q[g] == IDLE;
      assign start[g] = fire && issue_op == 2'(g);
      // ADD/SUB results are registered one cycle after start; MUL/DIV finish on busy's falling edge
      assign cmp[g] = (g < 2) || (bprev_q[g] && !busy[g]);
   end

   always_comb begin
      rr = ptr_q;
      for (int k = 3; k >= 0; k--)
         if (done[ptr_q + 2'(k)]) rr = ptr_q + 2'(k);
      // an unaccepted grant stays locked so the CDB payload cannot change under backpressure
      gnt = lock_q ? gnt_q : rr;
      wb_valid = |done && !flush && !rst;
      hs = wb_valid && wb_ready;
      issue_ready = !rst && !flush && (st_q[issue_op] == IDLE || (st_q[issue_op] == DONE && hs && gnt == issue_op));
      fire = issue_valid && issue_ready;
      wb_tag = wb_valid ? tag_q[gnt] : '0;
      wb_data = wb_valid ? hold_q[gnt] : '0;
      ptr_d = hs ? gnt + 2'd1 : ptr_q;
      lock_d = wb_valid && !wb_ready;
      gnt_d = gnt;
      bprev_d = busy;
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         st_d[i] = st_q[i];
         sq_d[i] = sq_q[i];
         tag_d[i] = tag_q[i];
         hold_d[i] = hold_q[i];
         if (flush) begin
            if (st_q[i] == DONE) st_d[i] = IDLE;
            if (st_q[i] == BUSY && cmp[i]) begin
               st_d[i] = IDLE;
               sq_d[i] = 1'b0;
            end else if (st_q[i] == BUSY) sq_d[i] = 1'b1;
         end else begin
            if (st_q[i] == BUSY && cmp[i]) begin
               st_d[i] = sq_q[i] ? IDLE : DONE;
               sq_d[i] = 1'b0;
               if (!sq_q[i]) hold_d[i] = res[i];
            end
            if (hs && gnt == 2'(i)) st_d[i] = IDLE;
            if (start[i]) begin
               st_d[i] = BUSY;
               tag_d[i] = issue_tag;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            st_q[i] <= IDLE;
            tag_q[i] <= '0;
            hold_q[i] <= '0;
         end
         sq_q <= '0;
         bprev_q <= '0;
         ptr_q <= '0;
         gnt_q <= '0;
         lock_q <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            st_q[i] <= st_d[i];
            tag_q[i] <= tag_d[i];
            hold_q[i] <= hold_d[i];
         end
         sq_q <= sq_d;
         bprev_q <= bprev_d;
         ptr_q <= ptr_d;
         gnt_q <= gnt_d;
         lock_q <= lock_d;
      end
   end
endmodule

// File: tb/tb_int_alu_scheduler.sv
// tb_int_alu_scheduler: cycle-level model of issue/completion/writeback plus directed scenarios.
module tb_int_alu_scheduler;
   localparam int DW = 32, TW = 6;
   logic clk = 1'b0, rst, issue_valid, flush, wb_ready, wb_valid, issue_ready;
   logic [1:0] issue_op;
   logic [DW-1:0] issue_a, issue_b, wb_data;
   logic [TW-1:0] issue_tag, wb_tag;
   logic [3:0] unit_free;
   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   int_alu_scheduler #(.DATA_W(DW), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_op(issue_op), .issue_a(issue_a),
      .issue_b(issue_b), .issue_tag(issue_tag), .issue_ready(issue_ready), .unit_free(unit_free),
      .flush(flush), .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_ready(wb_ready));

   // model: an op issued in cycle N has its result pending from cycle N+lat+1 until drained
   bit pend [4], infl [4], dead [4];
   int fdone [4];
   logic [TW-1:0] ptag [4], ftag [4];
   logic [DW-1:0] pdat [4], fdat [4];
   int ptr = 0, hold_g = 0, gcyc = 0;
   bit hold_v = 0;
   int lat [4] = '{1, 1, 5, 9};

   function automatic logic [DW-1:0] alu(int op, logic [DW-1:0] a, logic [DW-1:0] b);
      case (op)
         0: return a + b;
         1: return a - b;
         2: return a * b;
         default: return (b == 0) ? '0 : a / b;
      endcase
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin : model
      int g, op;
      bit ev, er, hs;
      logic [3:0] ef;
      g = ptr;
      for (int k = 3; k >= 0; k--) if (pend[(ptr + k) % 4]) g = (ptr + k) % 4;
      if (hold_v) g = hold_g;
      op = int'(issue_op);
      ev = !rst && !flush && (pend[0] || pend[1] || pend[2] || pend[3]);
      hs = ev && wb_ready;
      er = !rst && !flush && ((!pend[op] && !infl[op]) || (pend[op] && hs && g == op));
      for (int i = 0; i < 4; i++) ef[i] = !pend[i] && !infl[i];
      chk("m_wb_valid", 64'(wb_valid), 64'(ev));
      chk("m_wb_tag", 64'(wb_tag), ev ? 64'(ptag[g]) : 64'd0);
      chk("m_wb_data", 64'(wb_data), ev ? 64'(pdat[g]) : 64'd0);
      chk("m_unit_free", 64'(unit_free), 64'(ef));
      chk("m_issue_ready", 64'(issue_ready), 64'(er));
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            pend[i] = 0;
            infl[i] = 0;
            dead[i] = 0;
         end
         ptr = 0;
         hold_v = 0;
      end else begin
         hold_v = ev && !wb_ready;
         hold_g = g;
         for (int i = 0; i < 4; i++) begin
            if (flush) pend[i] = 0;
            if (infl[i] && fdone[i] == gcyc) begin
               infl[i] = 0;
               if (!dead[i] && !flush) begin
                  pend[i] = 1;
                  ptag[i] = ftag[i];
                  pdat[i] = fdat[i];
               end
               dead[i] = 0;
            end else if (infl[i] && flush) dead[i] = 1;
         end
         if (hs) begin
            pend[g] = 0;
            ptr = (g + 1) % 4;
         end
         if (issue_valid && er) begin
            infl[op] = 1;
            dead[op] = 0;
            fdone[op] = gcyc + lat[op];
            ftag[op] = issue_tag;
            fdat[op] = alu(op, issue_a, issue_b);
         end
      end
      gcyc++;
   end

   task automatic idle();
      issue_valid = 0;
      flush = 0;
      rst = 0;
   endtask

   task automatic issue(int op, logic [DW-1:0] a, logic [DW-1:0] b, logic [TW-1:0] t);
      issue_valid = 1;
      issue_op = 2'(op);
      issue_a = a;
      issue_b = b;
      issue_tag = t;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic do_reset();
      rst = 1;
      issue_valid = 0;
      flush = 0;
      issue_op = 0;
      @(posedge clk);
      #4;
      chk("rst_issue_ready", 64'(issue_ready), 64'd0);
      chk("rst_wb_valid", 64'(wb_valid), 64'd0);
      next();
      #3;
      chk("rst_unit_free", 64'(unit_free), 64'hf);
      chk("rst_wb_tag", 64'(wb_tag), 64'd0);
      chk("rst_wb_data", 64'(wb_data), 64'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1; issue_valid = 0; flush = 0; wb_ready = 1;
      issue_op = 0; issue_a = 0; issue_b = 0; issue_tag = 0;
      #1;
      // ADD latency
      do_reset(); wb_ready = 1;
      for (int c = 0; c < 5; c++) begin
         if (c == 0) issue(0, 5, 7, 3);
         #3;
         chk("add_valid", 64'(wb_valid), 64'(c == 2));
         if (c == 2) begin chk("add_data", 64'(wb_data), 12); chk("add_tag", 64'(wb_tag), 3); end
         if (c >= 1) chk("add_free0", 64'(unit_free[0]), 64'(!(c == 1 || c == 2)));
         next();
      end
      // MUL/ADD collision, round-robin from ADD
      do_reset(); wb_ready = 1;
      for (int c = 0; c < 9; c++) begin
         if (c == 0) issue(2, 6, 7, 1);
         if (c == 4) issue(0, 2, 3, 2);
         #3;
         chk("rr_valid", 64'(wb_valid), 64'(c == 6 || c == 7));
         if (c == 6) begin chk("rr_data6", 64'(wb_data), 5); chk("rr_tag6", 64'(wb_tag), 2); end
         if (c == 7) begin chk("rr_data7", 64'(wb_data), 42); chk("rr_tag7", 64'(wb_tag), 1); end
         next();
      end
      // DIV and divide by zero
      do_reset(); wb_ready = 1;
      for (int c = 0; c < 23; c++) begin
         if (c == 0) issue(3, 100, 7, 9);
         if (c == 11) issue(3, 100, 0, 10);
         #3;
         chk("div_valid", 64'(wb_valid), 64'(c == 10 || c == 21));
         if (c == 10) begin chk("div_data", 64'(wb_data), 14); chk("div_tag", 64'(wb_tag), 9); end
         if (c == 11) chk("div_rdy", 64'(issue_ready), 1);
         if (c == 21) begin chk("div0_data", 64'(wb_data), 0); chk("div0_tag", 64'(wb_tag), 10); end
         next();
      end
      // backpressure then drain+reissue in the same cycle
      do_reset();
      for (int c = 0; c < 9; c++) begin
         wb_ready = c >= 5;
         if (c == 0) issue(0, 1, 1, 5);
         if (c == 5) issue(0, 4, 5, 6);
         #3;
         chk("bp_valid", 64'(wb_valid), 64'((c >= 2 && c <= 5) || c == 7));
         if (c >= 2 && c <= 5) chk("bp_data", 64'(wb_data), 2);
         if (c >= 1 && c <= 4) chk("bp_rdy_lo", 64'(issue_ready), 0);
         if (c == 5) chk("bp_rdy_hi", 64'(issue_ready), 1);
         if (c == 7) begin chk("bp_data7", 64'(wb_data), 9); chk("bp_tag7", 64'(wb_tag), 6); end
         next();
      end
      // four units done, grant held under backpressure, then drained round-robin
      do_reset();
      for (int c = 0; c < 17; c++) begin
         wb_ready = c >= 12;
         if (c == 0) issue(3, 100, 3, 20);
         if (c == 4) issue(2, 3, 5, 22);
         if (c == 7) issue(1, 10, 4, 21);
         if (c == 8) issue(0, 8, 9, 23);
         #3;
         chk("rr4_valid", 64'(wb_valid), 64'(c >= 9 && c <= 15));
         if (c >= 9 && c <= 12) begin chk("rr4_hold_tag", 64'(wb_tag), 21); chk("rr4_hold_data", 64'(wb_data), 6); end
         if (c == 13) begin chk("rr4_mul_tag", 64'(wb_tag), 22); chk("rr4_mul_data", 64'(wb_data), 15); end
         if (c == 14) begin chk("rr4_div_tag", 64'(wb_tag), 20); chk("rr4_div_data", 64'(wb_data), 33); end
         if (c == 15) begin chk("rr4_add_tag", 64'(wb_tag), 23); chk("rr4_add_data", 64'(wb_data), 17); end
         next();
      end
      // flush a busy MUL and later a held ADD result
      do_reset(); wb_ready = 0;
      for (int c = 0; c < 13; c++) begin
         if (c == 0) issue(2, 3, 3, 7);
         if (c == 2) begin flush = 1; issue_op = 1; end
         if (c == 7) issue(0, 1, 2, 8);
         if (c == 10) flush = 1;
         #3;
         chk("fl_valid", 64'(wb_valid), 64'(c == 9));
         if (c == 2) chk("fl_rdy", 64'(issue_ready), 0);
         if (c >= 1 && c <= 12) chk("fl_free2", 64'(unit_free[2]), 64'(c >= 6));
         if (c == 11) chk("fl_free0", 64'(unit_free[0]), 1);
         next();
      end
      // reset while DIV is counting
      do_reset(); wb_ready = 1;
      for (int c = 0; c < 14; c++) begin
         if (c == 0) issue(3, 50, 5, 11);
         if (c == 3) rst = 1;
         #3;
         chk("rm_valid", 64'(wb_valid), 0);
         if (c == 2) chk("rm_free_busy", 64'(unit_free), 64'h7);
         if (c >= 4) chk("rm_free", 64'(unit_free), 64'hf);
         next();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
